// File: rtl/demux_cap_pkg.sv
// Shared constants and helpers for the 16-channel demux capture block.
package demux_cap_pkg;
  localparam int NUM_CH    = 16;
  localparam int CH_W      = 4;
  localparam int CNT_W_DEF = 8;

  // Lowest-numbered set bit wins; returns 0 for an all-zero vector.
  function automatic logic [CH_W-1:0] prio_enc(input logic [NUM_CH-1:0] v);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (v[i]) r = CH_W'(i);
    return r;
  endfunction

  // Population count >= 2: clearing the lowest set bit leaves something behind.
  function automatic logic is_multi_hot(input logic [NUM_CH-1:0] v);
    return (v & (v - NUM_CH'(1))) != '0;
  endfunction
endpackage

// File: rtl/demux16_capture_if.sv
// Bus between the demux/host side and the capture block.
interface demux16_capture_if #(parameter int CNT_W = demux_cap_pkg::CNT_W_DEF);
  import demux_cap_pkg::*;
  logic [NUM_CH-1:0] dout_in;
  logic              rd_en;
  logic [CH_W-1:0]   rd_addr;
  logic              clr_all;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_flag;
  logic [CH_W-1:0]   active_ch;
  logic              any_active;
  logic              multi_hot;
  logic              irq;

  modport master (output dout_in, rd_en, rd_addr, clr_all,
                  input  rd_valid, rd_data, rd_flag, active_ch, any_active, multi_hot, irq);
  modport slave  (input  dout_in, rd_en, rd_addr, clr_all,
                  output rd_valid, rd_data, rd_flag, active_ch, any_active, multi_hot, irq);
endinterface

// File: rtl/demux_cap_chan.sv
// One channel: rising-edge detect, saturating event counter, sticky flag.
module demux_cap_chan #(parameter int CNT_W = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic             rd_clr,
  input  logic             clr_all,
  output logic [CNT_W-1:0] cnt,
  output logic             flag
);
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, base;
  logic             flag_q, flag_d;
  logic             rise;

  assign rise = sample & ~prev_q;

  always_comb begin
    prev_d = sample;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    // A read-clear coinciding with an edge keeps the new event.
    base   = rd_clr ? '0 : cnt_q;
    if (clr_all) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else begin
      if (rd_clr) begin
        cnt_d  = '0;
        flag_d = 1'b0;
      end
      if (rise) begin
        cnt_d  = (base == {CNT_W{1'b1}}) ? base : base + CNT_W'(1);
        flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign cnt  = cnt_q;
  assign flag = flag_q;
endmodule

// File: rtl/demux16_capture.sv
// Captures rising edges on the one-hot demux bus into per-channel counters,
// with an addressed read-and-clear port and status/interrupt outputs.
module demux16_capture
  import demux_cap_pkg::*;
#(parameter int CNT_W = CNT_W_DEF) (
  input  logic              clk,
  input  logic              rst_n,
  demux16_capture_if.slave  bus
);
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]            flag, rd_clr;

  logic [NUM_CH-1:0] sample_q, sample_d;
  logic              multi_hot_q, multi_hot_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_flag_q, rd_flag_d;

  always_comb begin
    rd_clr = '0;
    if (bus.rd_en) rd_clr[bus.rd_addr] = 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_cap_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sample  (bus.dout_in[g]),
      .rd_clr  (rd_clr[g]),
      .clr_all (bus.clr_all),
      .cnt     (cnt[g]),
      .flag    (flag[g])
    );
  end

  // Read data is taken from the pre-edge counter state, so clears at the
  // same edge (per-channel or global) never corrupt the returned value.
  always_comb begin
    sample_d    = bus.dout_in;
    multi_hot_d = bus.clr_all ? 1'b0 : (multi_hot_q | is_multi_hot(bus.dout_in));
    rd_valid_d  = bus.rd_en;
    rd_data_d   = bus.rd_en ? cnt[bus.rd_addr]  : '0;
    rd_flag_d   = bus.rd_en ? flag[bus.rd_addr] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      multi_hot_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_flag_q   <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      multi_hot_q <= multi_hot_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_flag_q   <= rd_flag_d;
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_flag    = rd_flag_q;
  assign bus.active_ch  = prio_enc(sample_q);
  assign bus.any_active = |sample_q;
  assign bus.multi_hot  = multi_hot_q;
  assign bus.irq        = |flag;
endmodule

// File: tb/tb_demux16_capture.sv
// Directed-vector bench for demux16_capture.
module tb_demux16_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux16_capture_if #(.CNT_W(8)) bus ();
  demux16_capture #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, output logic v, output logic [7:0] d, output logic f);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    tick();
    v = bus.rd_valid; d = bus.rd_data; f = bus.rd_flag;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    bus.dout_in = '0; bus.rd_en = 1'b0; bus.rd_addr = '0; bus.clr_all = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    got = {bus.rd_valid, bus.rd_data, bus.rd_flag, bus.any_active, bus.multi_hot, bus.irq};
    checks++;
    if (got !== 14'h0 || bus.active_ch !== 4'h0) begin
      failures++; $display("FAIL reset_outputs got=%h ch=%h exp=0", got, bus.active_ch);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_onehot();
    logic v, f; logic [7:0] d;
    int chs[4] = '{0, 5, 10, 15};
    logic [15:0] hit;
    hit = 16'h8421;
    foreach (chs[k]) begin
      bus.dout_in = 16'h1 << chs[k];
      tick();
      checks++;
      if (bus.active_ch !== 4'(chs[k]) || bus.any_active !== 1'b1) begin
        failures++; $display("FAIL onehot_active ch=%0d got=%0d/%b exp=%0d/1", chs[k], bus.active_ch, bus.any_active, chs[k]);
      end
      tick();
    end
    bus.dout_in = '0;
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.multi_hot !== 1'b0 || bus.any_active !== 1'b0) begin
      failures++; $display("FAIL onehot_status irq=%b mh=%b any=%b exp=1/0/0", bus.irq, bus.multi_hot, bus.any_active);
    end
    for (int c = 0; c < 16; c++) begin
      do_read(4'(c), v, d, f);
      checks++;
      if (v !== 1'b1 || d !== (hit[c] ? 8'd1 : 8'd0) || f !== hit[c]) begin
        failures++; $display("FAIL onehot_read ch=%0d got v=%b d=%0d f=%b exp v=1 d=%0d f=%b", c, v, d, f, hit[c], hit[c]);
      end
    end
    tick();
    checks++;
    if (bus.irq !== 1'b0 || bus.rd_valid !== 1'b0) begin
      failures++; $display("FAIL onehot_cleared irq=%b rdv=%b exp=0/0", bus.irq, bus.rd_valid);
    end
  endtask

  task automatic test_saturate();
    logic v, f; logic [7:0] d;
    for (int i = 0; i < 300; i++) begin
      bus.dout_in = 16'h0080; tick();
      bus.dout_in = 16'h0000; tick();
    end
    do_read(4'd7, v, d, f);
    checks++;
    if (v !== 1'b1 || d !== 8'd255 || f !== 1'b1) begin
      failures++; $display("FAIL sat_read got v=%b d=%0d f=%b exp v=1 d=255 f=1", v, d, f);
    end
    do_read(4'd7, v, d, f);
    checks++;
    if (v !== 1'b1 || d !== 8'd0 || f !== 1'b0) begin
      failures++; $display("FAIL sat_reread got v=%b d=%0d f=%b exp v=1 d=0 f=0", v, d, f);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL sat_irq got=%b exp=0", bus.irq);
    end
  endtask

  task automatic test_read_edge();
    logic v, f; logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      bus.dout_in = 16'h0008; tick();
      bus.dout_in = 16'h0000; tick();
    end
    bus.dout_in = 16'h0008;
    do_read(4'd3, v, d, f);
    checks++;
    if (v !== 1'b1 || d !== 8'd4 || f !== 1'b1) begin
      failures++; $display("FAIL rdedge_first got v=%b d=%0d f=%b exp v=1 d=4 f=1", v, d, f);
    end
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++; $display("FAIL rdedge_irq got=%b exp=1", bus.irq);
    end
    bus.dout_in = 16'h0000;
    tick();
    do_read(4'd3, v, d, f);
    checks++;
    if (d !== 8'd1 || f !== 1'b1) begin
      failures++; $display("FAIL rdedge_second got d=%0d f=%b exp d=1 f=1", d, f);
    end
  endtask

  task automatic test_multi_hot();
    logic v, f; logic [7:0] d;
    bus.dout_in = 16'h0003; tick();
    checks++;
    if (bus.multi_hot !== 1'b1 || bus.active_ch !== 4'd0 || bus.any_active !== 1'b1) begin
      failures++; $display("FAIL mh_set got mh=%b ch=%0d any=%b exp 1/0/1", bus.multi_hot, bus.active_ch, bus.any_active);
    end
    bus.dout_in = 16'h0000;
    repeat (3) tick();
    checks++;
    if (bus.multi_hot !== 1'b1 || bus.any_active !== 1'b0) begin
      failures++; $display("FAIL mh_sticky got mh=%b any=%b exp 1/0", bus.multi_hot, bus.any_active);
    end
    // clr_all with a simultaneous edge on channel 2
    bus.clr_all = 1'b1; bus.dout_in = 16'h0004;
    tick();
    bus.clr_all = 1'b0;
    checks++;
    if (bus.multi_hot !== 1'b0 || bus.irq !== 1'b0) begin
      failures++; $display("FAIL clr_all_status got mh=%b irq=%b exp 0/0", bus.multi_hot, bus.irq);
    end
    tick();
    bus.dout_in = 16'h0000;
    do_read(4'd2, v, d, f);
    checks++;
    if (d !== 8'd0 || f !== 1'b0) begin
      failures++; $display("FAIL clr_all_ch2 got d=%0d f=%b exp 0/0", d, f);
    end
    // read coinciding with clr_all returns pre-clear values
    bus.dout_in = 16'h0200; tick();
    bus.dout_in = 16'h0000;
    bus.clr_all = 1'b1;
    do_read(4'd9, v, d, f);
    bus.clr_all = 1'b0;
    checks++;
    if (v !== 1'b1 || d !== 8'd1 || f !== 1'b1) begin
      failures++; $display("FAIL rd_clr_all got v=%b d=%0d f=%b exp 1/1/1", v, d, f);
    end
    do_read(4'd9, v, d, f);
    checks++;
    if (d !== 8'd0 || f !== 1'b0) begin
      failures++; $display("FAIL rd_clr_all_after got d=%0d f=%b exp 0/0", d, f);
    end
  endtask

  task automatic test_reset_high();
    logic v, f; logic [7:0] d;
    rst_n = 1'b0;
    bus.dout_in = 16'h0100;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.active_ch !== 4'd8) begin
      failures++; $display("FAIL rsthigh_edge got irq=%b ch=%0d exp 1/8", bus.irq, bus.active_ch);
    end
    bus.dout_in = 16'h0000;
    tick();
    do_read(4'd8, v, d, f);
    checks++;
    if (v !== 1'b1 || d !== 8'd1 || f !== 1'b1) begin
      failures++; $display("FAIL rsthigh_read got v=%b d=%0d f=%b exp 1/1/1", v, d, f);
    end
  endtask

  task automatic test_reset_inflight();
    logic [13:0] got;
    bus.dout_in = 16'h0011; tick();
    bus.rd_en = 1'b1; bus.rd_addr = 4'd4;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    got = {bus.rd_valid, bus.rd_data, bus.rd_flag, bus.any_active, bus.multi_hot, bus.irq};
    checks++;
    if (got !== 14'h0 || bus.active_ch !== 4'h0) begin
      failures++; $display("FAIL async_reset got=%h ch=%0d exp=0", got, bus.active_ch);
    end
    bus.dout_in = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.irq !== 1'b0) begin
      failures++; $display("FAIL async_reset_after rdv=%b irq=%b exp 0/0", bus.rd_valid, bus.irq);
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_saturate();
    test_read_edge();
    test_multi_hot();
    test_reset_high();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
